// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined Hack ALU: comp codes, extended ops, FSM states.
package alu_pkg;

    localparam logic [5:0] H_ZERO = 6'b101010;
    localparam logic [5:0] H_ONE  = 6'b111111;
    localparam logic [5:0] H_NEG1 = 6'b111010;
    localparam logic [5:0] H_X    = 6'b001100;
    localparam logic [5:0] H_Y    = 6'b110000;
    localparam logic [5:0] H_NOTX = 6'b001101;
    localparam logic [5:0] H_NOTY = 6'b110001;
    localparam logic [5:0] H_NEGX = 6'b001111;
    localparam logic [5:0] H_NEGY = 6'b110011;
    localparam logic [5:0] H_XP1  = 6'b011111;
    localparam logic [5:0] H_YP1  = 6'b110111;
    localparam logic [5:0] H_XM1  = 6'b001110;
    localparam logic [5:0] H_YM1  = 6'b110010;
    localparam logic [5:0] H_ADD  = 6'b000010;
    localparam logic [5:0] H_XMY  = 6'b010011;
    localparam logic [5:0] H_YMX  = 6'b000111;
    localparam logic [5:0] H_AND  = 6'b000000;
    localparam logic [5:0] H_OR   = 6'b010101;

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SAR  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_REMU = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_e;

    function automatic logic is_iter_op(input logic [6:0] op);
        return op[6] && (op[2:0] == OP_MUL || op[2:0] == OP_DIVU || op[2:0] == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative datapath: shift-add multiply or restoring divide, one bit per cycle.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             mode_mul_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             mul_q, mul_d;
    logic [WIDTH:0]   shifted;

    // p: accumulator (MUL) or partial remainder (DIV); a: multiplier or dividend/quotient
    always_comb begin
        cnt_d   = cnt_q;
        p_d     = p_q;
        a_d     = a_q;
        b_d     = b_q;
        mul_d   = mul_q;
        shifted = {p_q, a_q[WIDTH-1]};
        if (start_i) begin
            cnt_d = CW'(WIDTH);
            p_d   = '0;
            a_d   = a_i;
            b_d   = b_i;
            mul_d = mode_mul_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            if (mul_q) begin
                if (a_q[0]) p_d = p_q + b_q;
                a_d = a_q >> 1;
                b_d = b_q << 1;
            end else if (shifted >= {1'b0, b_q}) begin
                // divisor of zero always lands here: quotient all ones, remainder = dividend
                p_d = WIDTH'(shifted - {1'b0, b_q});
                a_d = {a_q[WIDTH-2:0], 1'b1};
            end else begin
                p_d = shifted[WIDTH-1:0];
                a_d = {a_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            p_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            mul_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            p_q   <= p_d;
            a_q   <= a_d;
            b_q   <= b_d;
            mul_q <= mul_d;
        end
    end

    // High while the final step is being taken this cycle
    assign done_o = (cnt_q == CW'(1));
    assign prod_o = p_q;
    assign quot_o = a_q;
    assign rem_o  = p_q;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked Hack ALU: single-cycle comp codes and shifts, iterative MUL/DIVU/REMU, registered flags.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zr,
    output logic             ng
);
    localparam int SW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zr_q, zr_d, ng_q, ng_d, vld_q, vld_d;

    logic [WIDTH-1:0] single_val, iter_val, wr_val;
    logic [WIDTH-1:0] prod, quot, rem;
    logic [SW-1:0]    sh;
    logic             fire, iter_op, start, wr_en, done, mode_mul;

    assign sh       = y[SW-1:0];
    assign in_ready = (state_q == IDLE) && (!vld_q || out_ready);
    assign fire     = in_valid && in_ready;
    assign iter_op  = is_iter_op(opcode);
    assign mode_mul = (opcode[2:0] == OP_MUL);

    always_comb begin
        single_val = '0;
        if (opcode[6]) begin
            case (opcode[2:0])
                OP_SHL:  single_val = x << sh;
                OP_SHR:  single_val = x >> sh;
                OP_SAR:  single_val = WIDTH'($signed(x) >>> sh);
                default: single_val = '0;
            endcase
        end else begin
            case (opcode[5:0])
                H_ZERO:  single_val = '0;
                H_ONE:   single_val = WIDTH'(1);
                H_NEG1:  single_val = '1;
                H_X:     single_val = x;
                H_Y:     single_val = y;
                H_NOTX:  single_val = ~x;
                H_NOTY:  single_val = ~y;
                H_NEGX:  single_val = -x;
                H_NEGY:  single_val = -y;
                H_XP1:   single_val = x + WIDTH'(1);
                H_YP1:   single_val = y + WIDTH'(1);
                H_XM1:   single_val = x - WIDTH'(1);
                H_YM1:   single_val = y - WIDTH'(1);
                H_ADD:   single_val = x + y;
                H_XMY:   single_val = x - y;
                H_YMX:   single_val = y - x;
                H_AND:   single_val = x & y;
                H_OR:    single_val = x | y;
                default: single_val = '0;
            endcase
        end
    end

    alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .mode_mul_i (mode_mul),
        .a_i        (mode_mul ? y : x),
        .b_i        (mode_mul ? x : y),
        .done_o     (done),
        .prod_o     (prod),
        .quot_o     (quot),
        .rem_o      (rem)
    );

    always_comb begin
        case (op_q)
            OP_MUL:  iter_val = prod;
            OP_DIVU: iter_val = quot;
            default: iter_val = rem;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        start   = 1'b0;
        wr_en   = 1'b0;
        wr_val  = single_val;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    if (iter_op) begin
                        start   = 1'b1;
                        op_d    = opcode[2:0];
                        state_d = BUSY;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (done) state_d = FINISH;
            end
            FINISH: begin
                // Wait here rather than overwrite a result the consumer has not taken
                if (!vld_q || out_ready) begin
                    wr_en   = 1'b1;
                    wr_val  = iter_val;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        res_d = res_q;
        zr_d  = zr_q;
        ng_d  = ng_q;
        vld_d = vld_q;
        if (wr_en) begin
            res_d = wr_val;
            zr_d  = (wr_val == '0);
            ng_d  = wr_val[WIDTH-1];
            vld_d = 1'b1;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            res_q   <= '0;
            zr_q    <= 1'b1;
            ng_q    <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zr_q    <= zr_d;
            ng_q    <= ng_d;
            vld_q   <= vld_d;
        end
    end

    assign out_valid = vld_q;
    assign result    = res_q;
    assign zr        = zr_q;
    assign ng        = ng_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=16): directed vector table, handshake corner sequences, random vs model.
module tb_alu_pipe;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [6:0]   opcode;
    logic [W-1:0] x, y, result;
    logic         zr, ng;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zr        (zr),
        .ng        (ng)
    );

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [15:0] a, b, r;
        logic       z, n;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic add_vec(input string name, input logic [6:0] op, input logic [15:0] a, b, r,
                           input logic z, n, input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.r = r; v.z = z; v.n = n; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Behavioural model from the operation rules, plain integer arithmetic
    function automatic logic [15:0] ref_alu(input logic [6:0] op, input logic [15:0] a, b);
        int unsigned ua, ub, r;
        int sa, s;
        ua = a; ub = b; s = int'(b[3:0]); sa = int'($signed(a)); r = 0;
        if (op[6]) begin
            case (op[2:0])
                3'd0: r = ua << s;
                3'd1: r = ua >> s;
                3'd2: r = unsigned'(sa >>> s);
                3'd3: r = ua * ub;
                3'd4: r = (ub == 0) ? 32'hFFFF : ua / ub;
                3'd5: r = (ub == 0) ? ua : ua % ub;
                default: r = 0;
            endcase
        end else begin
            case (op[5:0])
                6'b101010: r = 0;
                6'b111111: r = 1;
                6'b111010: r = 32'hFFFF;
                6'b001100: r = ua;
                6'b110000: r = ub;
                6'b001101: r = ~ua;
                6'b110001: r = ~ub;
                6'b001111: r = 0 - ua;
                6'b110011: r = 0 - ub;
                6'b011111: r = ua + 1;
                6'b110111: r = ub + 1;
                6'b001110: r = ua - 1;
                6'b110010: r = ub - 1;
                6'b000010: r = ua + ub;
                6'b010011: r = ua - ub;
                6'b000111: r = ub - ua;
                6'b000000: r = ua & ub;
                6'b010101: r = ua | ub;
                default:   r = 0;
            endcase
        end
        return r[15:0];
    endfunction

    // Offer one op with out_ready=1; lat = edges after acceptance until out_valid shows
    task automatic run_op(input logic [6:0] op, input logic [15:0] a, b,
                          output logic [15:0] r, output logic z, output logic nflag,
                          output int lat, output bit rdy_seen);
        int nw;
        @(negedge clk);
        in_valid = 1'b1; opcode = op; x = a; y = b;
        nw = 0;
        while (!in_ready && nw < 50) begin @(negedge clk); nw++; end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; opcode = 7'($urandom); x = 16'($urandom); y = 16'($urandom);
        lat = 0; rdy_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("result_timeout", 32'd0, 32'd1);
        r = result; z = zr; nflag = ng;
    endtask

    logic [5:0] hcodes [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                                6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                                6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

    initial begin
        logic [15:0] r, ea, eb, er;
        logic [6:0]  op;
        logic        z, nf;
        int          lat;
        bit          rdy_seen, stale;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; opcode = '0; x = '0; y = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_zr", zr, 1);
        check("rst_ng", ng, 0);
        rst = 1'b0;
        #1 check("rst_in_ready", in_ready, 1);

        // Back-to-back single-cycle ops
        @(negedge clk);
        in_valid = 1'b1; opcode = 7'b0000010; x = 16'h0005; y = 16'h0003;
        check("b2b_rdy0", in_ready, 1);
        @(negedge clk);
        check("b2b_valid0", out_valid, 1);
        check("b2b_res0", result, 16'h0008);
        check("b2b_zr0", zr, 0);
        check("b2b_ng0", ng, 0);
        opcode = 7'b0010011;
        #1 check("b2b_rdy1", in_ready, 1);
        @(negedge clk);
        check("b2b_valid1", out_valid, 1);
        check("b2b_res1", result, 16'h0002);
        in_valid = 1'b0;

        add_vec("add",      7'b0000010, 16'h0005, 16'h0003, 16'h0008, 0, 0, 0);
        add_vec("x_minus_y",7'b0010011, 16'h0005, 16'h0003, 16'h0002, 0, 0, 0);
        add_vec("neg_x",    7'b0001111, 16'h0001, 16'h0000, 16'hFFFF, 0, 1, 0);
        add_vec("zero",     7'b0101010, 16'h1234, 16'h5678, 16'h0000, 1, 0, 0);
        add_vec("mul",      7'b1000011, 16'h0123, 16'h0010, 16'h1230, 0, 0, 17);
        add_vec("divu",     7'b1000100, 16'h0064, 16'h0007, 16'h000E, 0, 0, 17);
        add_vec("remu",     7'b1000101, 16'h0064, 16'h0007, 16'h0002, 0, 0, 17);
        add_vec("divu_by0", 7'b1000100, 16'h1234, 16'h0000, 16'hFFFF, 0, 1, 17);
        add_vec("remu_by0", 7'b1000101, 16'h1234, 16'h0000, 16'h1234, 0, 0, 17);
        add_vec("mul_wrap", 7'b1000011, 16'hFFFF, 16'hFFFF, 16'h0001, 0, 0, 17);
        add_vec("shl",      7'b1000000, 16'h0001, 16'h0004, 16'h0010, 0, 0, 0);
        add_vec("shl_lowy", 7'b1000000, 16'h0003, 16'h0011, 16'h0006, 0, 0, 0);
        add_vec("shr",      7'b1000001, 16'h8000, 16'h0004, 16'h0800, 0, 0, 0);
        add_vec("sar",      7'b1000010, 16'h8000, 16'h0004, 16'hF800, 0, 1, 0);
        add_vec("y_minus_x",7'b0000111, 16'h0003, 16'h0005, 16'h0002, 0, 0, 0);
        add_vec("and",      7'b0000000, 16'hF0F0, 16'hFF00, 16'hF000, 0, 1, 0);
        add_vec("or",       7'b0010101, 16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, 0);
        add_vec("not_y",    7'b0110001, 16'h0000, 16'h00FF, 16'hFF00, 0, 1, 0);
        add_vec("y_dec",    7'b0110010, 16'h0000, 16'h0000, 16'hFFFF, 0, 1, 0);
        add_vec("bad_hack", 7'b0000001, 16'h1234, 16'h5678, 16'h0000, 1, 0, 0);
        add_vec("ext_110",  7'b1000110, 16'h1234, 16'h5678, 16'h0000, 1, 0, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, nf, lat, rdy_seen);
            check({vecs[i].name, "_res"}, r, vecs[i].r);
            check({vecs[i].name, "_zr"}, z, vecs[i].z);
            check({vecs[i].name, "_ng"}, nf, vecs[i].n);
            check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
            if (vecs[i].lat != 0) check({vecs[i].name, "_busy_rdy"}, rdy_seen, 0);
        end

        // Back-pressure: pending result blocks the next op and stays stable
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = 7'b0000010; x = 16'h0005; y = 16'h0003;
        @(negedge clk);
        opcode = 7'b1000010; x = 16'h8000; y = 16'h0004;
        check("bp_valid", out_valid, 1);
        check("bp_res", result, 16'h0008);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall_rdy", in_ready, 0);
            check("bp_stall_res", result, 16'h0008);
            check("bp_stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1 check("bp_release_rdy", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        check("bp_sar_res", result, 16'hF800);
        check("bp_sar_ng", ng, 1);
        @(negedge clk);
        check("bp_sar_hold", result, 16'hF800);
        check("bp_sar_valid", out_valid, 1);

        // Reset in the middle of a multiply
        out_ready = 1'b1;
        in_valid = 1'b1; opcode = 7'b1000011; x = 16'h0123; y = 16'h0010;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_res", result, 0);
        check("midrst_zr", zr, 1);
        check("midrst_ng", ng, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_rdy", in_ready, 1);
        stale = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("midrst_no_stale", stale, 0);

        // Random ops against the model
        for (int i = 0; i < 150; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 5)       op = {1'b0, hcodes[$urandom_range(0, 17)]};
            else if (sel == 5) op = {1'b0, 6'($urandom)};
            else               op = {4'b1000, 3'($urandom)};
            ea = 16'($urandom);
            eb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            er = ref_alu(op, ea, eb);
            run_op(op, ea, eb, r, z, nf, lat, rdy_seen);
            check("rand_res", r, er);
            check("rand_zr", z, (er == 16'h0));
            check("rand_ng", nf, er[15]);
            check("rand_lat", lat, (op[6] && (op[2:0] == 3'd3 || op[2:0] == 3'd4 || op[2:0] == 3'd5)) ? 17 : 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the single-cycle Hack ALU in the CPU datapath. It keeps the 6-bit Hack compute encoding for its single-cycle operations. It adds shifts, plus iterative unsigned multiply, divide and remainder. It also adds valid/ready flow control and registered zero/negative flags, so a multi-cycle execute stage can stall on it.

## Interface
- WIDTH, 16: operand/result width; legal range 4..64.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted on any edge where in_valid && in_ready.
- opcode  in  7  bit6=0: Hack comp code in [5:0]; bit6=1: extended op in [2:0].
- x  in  WIDTH  first operand (D).
- y  in  WIDTH  second operand (A or M).
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result on out_valid && out_ready.
- result  out  WIDTH  registered result.
- zr  out  1  result == 0.
- ng  out  1  result[WIDTH-1].

## Operation
- Hack ops (bit6=0) use the 18 codes of the existing ALU with identical semantics, widened to WIDTH:
  - 101010=0, 111111=1, 111010=all ones.
  - 001100=x, 110000=y, 001101=~x, 110001=~y, 001111=-x, 110011=-y.
  - 011111=x+1, 110111=y+1, 001110=x-1, 110010=y-1.
  - 000010=x+y, 010011=x-y, 000111=y-x, 000000=x&y, 010101=x|y.
  - Any other code gives 0.
- Extended ops (bit6=1), shift amount s = y[clog2(WIDTH)-1:0]:
  - 000 SHL x<<s; 001 SHR logical; 010 SAR arithmetic.
  - 011 MUL: low WIDTH bits of x*y.
  - 100 DIVU: x/y. 101 REMU: x%y.
  - 110 and 111 give 0.
- All arithmetic is modulo 2^WIDTH.
- Divide by zero: DIVU returns all ones, REMU returns x, completing in the normal WIDTH+1 cycles.
- Shifts and Hack ops are single-cycle. MUL, DIVU and REMU are iterative: shift-add or restoring division, one bit per cycle.
- FSM states:
  - IDLE: accepts a single-cycle op and writes the output register directly. A multi-cycle op latches its operands, loads the counter with WIDTH, and moves to BUSY.
  - BUSY: one step per cycle; the counter decrements.
  - FINISH: on the cycle after the counter reaches 0, writes the output register and returns to IDLE.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- The output register (result, zr, ng) loads only when a new result is written. It stays stable while out_valid && !out_ready.
- out_valid clears on a consumer handshake unless a new result is written on the same edge; the new write wins.
- Reset (any time, including mid-BUSY):
  - state returns to IDLE and the counter goes to 0.
  - out_valid=0, result=0, zr=1, ng=0; in_ready becomes 1 once rst deasserts.
  - In-flight operands are discarded.

## Timing
- Single-cycle op accepted at edge k: out_valid=1 with the result after edge k.
- Back-to-back single-cycle ops sustain one op per cycle while out_ready=1.
- Multi-cycle op accepted at edge k:
  - steps occur at edges k+1..k+WIDTH;
  - result is written at edge k+WIDTH+1;
  - in_ready=0 from after edge k until the result is written.
- When the FINISH write would land on an un-taken result (out_valid && !out_ready), FSM holds in FINISH until the slot frees. No result is dropped or overwritten.
- in_valid, opcode, x and y are sampled only on the accepting edge. Later changes do not affect the operation in flight.

## Structure
- Package alu_pkg holds:
  - Hack comp-code localparams;
  - extended-op localparams (OP_SHL..OP_REMU);
  - state enum {IDLE, BUSY, FINISH}.
- Sub-module alu_iter (WIDTH-parametrised) is the iterative MUL/DIV/REMU datapath: start, mode, operands, done, product/quotient/remainder.
- alu_pipe owns the handshake, the FSM, the single-cycle op mux and the output register.

## Test plan
- WIDTH=16, back-to-back ops, out_ready=1:
  - x=0x0005, y=0x0003, opcode 0000010 then 0010011;
  - required: results 0x0008 (zr=0, ng=0) then 0x0002 on consecutive cycles, in_ready held 1.
- Opcode 0001111 (-x), x=0x0001: required 0xFFFF, ng=1. Opcode 0101010: required 0x0000, zr=1.
- MUL, x=0x0123, y=0x0010:
  - required: result 0x1230 with out_valid exactly 17 cycles after acceptance;
  - in_ready=0 throughout.
- DIVU, x=0x0064, y=0x0007: required 0x000E. REMU, same operands: required 0x0002.
- DIVU and REMU with y=0, x=0x1234: required 0xFFFF and 0x1234.
- Back-pressure and reset, out_ready=0:
  - with a result pending, offer SAR x=0x8000, y=4: in_ready stays 0 and result stays unchanged;
  - after out_ready=1 for one edge, SAR is accepted and yields 0xF800;
  - assert rst mid-MUL: outputs return to reset values immediately and no stale result appears afterwards.
